// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with a 4-bit instruction register and the BYPASS and IDCODE data registers.
// It drives the boundary-scan control strobes and the TDO serial mux.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0A5B
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                bsr_tdo,
  output logic                TDO,
  output logic                tdo_en,
  output logic                dr_capture,
  output logic                dr_shift,
  output logic                dr_update,
  output logic                bsr_select,
  output logic                mode,
  output logic                tlr_reset,
  output logic [IR_WIDTH-1:0] ir_value
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(2);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir, ir_shift;
  logic                bypass_reg;
  logic [31:0]         id_shift;
  logic                sel_idcode, sel_bypass;

  always_ff @(posedge TCK) begin
    if (TRST) state <= TLR;
    else begin
      unique case (state)
        TLR:      state <= TMS ? TLR      : RTI;
        RTI:      state <= TMS ? SEL_DR   : RTI;
        SEL_DR:   state <= TMS ? SEL_IR   : CAP_DR;
        CAP_DR:   state <= TMS ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state <= TMS ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state <= TMS ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state <= TMS ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state <= TMS ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state <= TMS ? SEL_DR   : RTI;
        SEL_IR:   state <= TMS ? TLR      : CAP_IR;
        CAP_IR:   state <= TMS ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state <= TMS ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state <= TMS ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state <= TMS ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state <= TMS ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state <= TMS ? SEL_DR   : RTI;
        default:  state <= TLR;
      endcase
    end
  end

  // ir moves only on reset, in TLR, or in UPD_IR; ir_shift is the serial staging copy
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir       <= OP_IDCODE;
      ir_shift <= '0;
    end else begin
      if (state == TLR)         ir <= OP_IDCODE;
      else if (state == UPD_IR) ir <= ir_shift;
      if (state == CAP_IR)        ir_shift <= IR_WIDTH'(1);
      else if (state == SHIFT_IR) ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
    end
  end

  assign bsr_select = (ir == OP_EXTEST) || (ir == OP_SAMPLE);
  assign mode       = (ir == OP_EXTEST);
  assign sel_idcode = (ir == OP_IDCODE);
  assign sel_bypass = !bsr_select && !sel_idcode;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      bypass_reg <= 1'b0;
      id_shift   <= '0;
    end else begin
      if (sel_bypass) begin
        if (state == CAP_DR)        bypass_reg <= 1'b0;
        else if (state == SHIFT_DR) bypass_reg <= TDI;
      end
      if (sel_idcode) begin
        if (state == CAP_DR)        id_shift <= IDCODE_VALUE;
        else if (state == SHIFT_DR) id_shift <= {TDI, id_shift[31:1]};
      end
    end
  end

  // Strobes are raw state decodes, so the BSR acts on the edge leaving each state
  assign dr_capture = (state == CAP_DR);
  assign dr_shift   = (state == SHIFT_DR);
  assign dr_update  = (state == UPD_DR);
  assign tlr_reset  = (state == TLR);
  assign tdo_en     = (state == SHIFT_DR) || (state == SHIFT_IR);
  assign ir_value   = ir;

  always_comb begin
    TDO = 1'b0;
    if (state == SHIFT_IR) TDO = ir_shift[0];
    else if (state == SHIFT_DR) begin
      if (bsr_select)      TDO = bsr_tdo;
      else if (sel_idcode) TDO = id_shift[0];
      else                 TDO = bypass_reg;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl. Expected serial TDO bits are queued as stimulus is driven,
// then popped and compared as the DUT shifts them out.
module tb_jtag_tap_ctrl;

  logic       TCK = 1'b0, TRST, TMS, TDI, bsr_tdo;
  logic       TDO, tdo_en, dr_capture, dr_shift, dr_update, bsr_select, mode, tlr_reset;
  logic [3:0] ir_value;

  int   total  = 0;
  int   passed = 0;
  int   nfail  = 0;
  logic exp_q[$];

  localparam logic [31:0] IDC = 32'h1000_0A5B;

  jtag_tap_ctrl #(.IR_WIDTH(4), .IDCODE_VALUE(IDC)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
    .TDO(TDO), .tdo_en(tdo_en), .dr_capture(dr_capture), .dr_shift(dr_shift),
    .dr_update(dr_update), .bsr_select(bsr_select), .mode(mode),
    .tlr_reset(tlr_reset), .ir_value(ir_value)
  );

  always #5 TCK = ~TCK;

  task automatic step(input logic tms_i, input logic tdi_i);
    TMS = tms_i;
    TDI = tdi_i;
    @(posedge TCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tdo(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      nfail++;
      $error("FAIL %s: observed %b expected <scoreboard empty>", tag, TDO);
    end else chk(tag, 32'(TDO), 32'(exp_q.pop_front()));
  endtask

  // Walk RTI -> SHIFT_IR, shift in op (LSB first) checking captured 0001 on TDO, exit to RTI
  task automatic load_ir(input logic [3:0] op, input string tag);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_tdo(tag);
      step(i == 3, op[i]);
    end
    step(1, 0);
    chk({tag, "_before_upd"}, 32'(ir_value), 32'(dut.ir));
    step(0, 0);
  endtask

  initial begin
    logic [3:0] pat;
    int         en_cnt;
    TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; bsr_tdo = 1'b0;
    @(posedge TCK); #1;
    @(posedge TCK); #1;
    chk("rst_tlr",     32'(tlr_reset), 32'd1);
    chk("rst_ir",      32'(ir_value),  32'h1);
    chk("rst_sel_mode", 32'({bsr_select, mode}), 32'd0);
    chk("rst_dr",      32'({dr_capture, dr_shift, dr_update}), 32'd0);
    chk("rst_tdo",     32'({tdo_en, TDO}), 32'd0);
    TRST = 1'b0;

    step(1, 0); step(1, 0); step(1, 0);
    chk("tlr_hold", 32'(tlr_reset), 32'd1);
    chk("tlr_ir",   32'({ir_value, bsr_select, mode}), 32'b0001_0_0);

    // IDCODE read
    step(0, 0); step(1, 0); step(0, 0);
    chk("id_capture", 32'(dr_capture), 32'd1);
    step(0, 0);
    for (int i = 0; i < 32; i++) exp_q.push_back(IDC[i]);
    en_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (tdo_en) en_cnt++;
      chk_tdo("idcode_bit");
      step(i == 31, 0);
    end
    chk("id_tdo_en_cycles", 32'(en_cnt), 32'd32);
    step(1, 0);
    chk("id_update", 32'(dr_update), 32'd1);
    step(0, 0);
    chk("id_rti_update_off", 32'(dr_update), 32'd0);

    // EXTEST
    load_ir(4'b0000, "ir_extest");
    chk("extest_decode", 32'({ir_value, bsr_select, mode}), 32'b0000_1_1);

    step(1, 0); step(0, 0);
    chk("ext_capture", 32'({dr_capture, dr_shift}), 32'b10);
    step(1, 0); step(0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("pause_no_shift", 32'({dr_shift, tdo_en, dr_capture}), 32'd0);
      if (i < 2) step(0, 0);
    end
    step(1, 0); step(0, 0);
    chk("resume_shift", 32'({dr_shift, dr_capture}), 32'b10);
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      bsr_tdo = pat[i];
      exp_q.push_back(pat[i]);
      #1;
      chk_tdo("extest_bsr_tdo");
    end
    step(1, 0); step(1, 0);
    chk("ext_update", 32'(dr_update), 32'd1);
    step(0, 0);
    chk("ext_update_1cyc", 32'(dr_update), 32'd0);

    // BYPASS: TDO lags TDI by one edge; bsr_tdo held high must not leak through
    bsr_tdo = 1'b1;
    load_ir(4'b1111, "ir_bypass");
    chk("bypass_decode", 32'({ir_value, bsr_select, mode}), 32'b1111_0_0);
    step(1, 0); step(0, 0);
    chk("byp_capture", 32'(dr_capture), 32'd1);
    step(0, 0);
    chk("byp_capture_1cyc", 32'({dr_capture, dr_shift}), 32'b01);
    pat = 4'b1101;
    exp_q.push_back(1'b0);
    for (int j = 0; j < 5; j++) begin
      chk_tdo("bypass_tdo");
      if (j < 4) begin
        exp_q.push_back(pat[j]);
        step(0, pat[j]);
      end
    end
    step(1, 0); step(1, 0); step(0, 0);

    // TRST mid IR shift
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 0);
    chk("pre_trst_ir", 32'({tdo_en, ir_value}), 32'b1_1111);
    TRST = 1'b1;
    step(0, 0);
    TRST = 1'b0;
    chk("trst_tlr", 32'({tlr_reset, tdo_en}), 32'b10);
    chk("trst_ir",  32'(ir_value), 32'h1);

    // Five TMS=1 from PAUSE_DR
    step(0, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    chk("in_pause", 32'({tlr_reset, dr_shift}), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 0);
    chk("four_tms_not_tlr", 32'(tlr_reset), 32'd0);
    step(1, 0);
    chk("five_tms_tlr", 32'(tlr_reset), 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
